// File: rtl/updown_sweep_ctrl_pkg.sv
// Shared types and constants for the up/down triangle-sweep sequencer.
package updown_pkg;

    // Default counter width and sweep-count width.
    localparam int unsigned N_DEF  = 4;
    localparam int unsigned SW_DEF = 4;

    // Direction encoding seen by the counter's up_down input.
    localparam logic DIR_UP = 1'b1;
    localparam logic DIR_DN = 1'b0;

    // Sequencer states.
    typedef enum logic [1:0] {
        IDLE,
        UP,
        DOWN,
        DONE
    } state_t;

endpackage

// File: rtl/updown_sweep_ctrl_counter.sv
// Free-running N-bit up/down counter with synchronous clear and no hold.
module up_down_counter #(
    parameter int unsigned N = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         up_down,
    output logic [N-1:0] count
);

    // Clear on rst, otherwise step by one every clock in the selected direction.
    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (up_down) begin
            count <= count + N'(1);
        end else begin
            count <= count - N'(1);
        end
    end

endmodule

// File: rtl/updown_sweep_ctrl.sv
// Triangle-sweep sequencer: runs the up/down counter 0 -> hi -> 0, n_sweeps times.
module updown_sweep_ctrl
    import updown_pkg::*;
#(
    parameter int unsigned N  = N_DEF,
    parameter int unsigned SW = SW_DEF
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          stop,
    input  logic [N-1:0]  hi,
    input  logic [SW-1:0] n_sweeps,
    output logic [N-1:0]  count,
    output logic          dir,
    output logic          busy,
    output logic [SW-1:0] sweep_idx,
    output logic          done
);

    state_t        state_q, state_d;
    logic [N-1:0]  hi_q, hi_d;
    logic [SW-1:0] n_q, n_d;
    logic [SW-1:0] idx_q, idx_d;
    logic          cnt_rst_q, cnt_rst_d;
    logic          dir_q, dir_d;
    logic          ctr_rst;
    logic          running;

    assign running = (state_q == UP) || (state_q == DOWN);

    // The counter has one edge of latency from its inputs, so a registered clear alone
    // would let it step once more on the reset/abort edge. rst and an accepted stop are
    // folded in combinationally; neither depends on count, so there is no loop.
    assign ctr_rst = rst | cnt_rst_q | (stop & running);

    up_down_counter #(
        .N (N)
    ) u_counter (
        .clk     (clk),
        .rst     (ctr_rst),
        .up_down (dir_q),
        .count   (count)
    );

    // Next-state and next-output decode; look-ahead on count so dir flips as the peak
    // or the floor is reached rather than one edge late.
    always_comb begin
        state_d   = state_q;
        hi_d      = hi_q;
        n_d       = n_q;
        idx_d     = idx_q;
        cnt_rst_d = cnt_rst_q;
        dir_d     = dir_q;

        unique case (state_q)
            IDLE: begin
                cnt_rst_d = 1'b1;
                dir_d     = DIR_UP;
                if (start) begin
                    if ((hi != '0) && (n_sweeps != '0)) begin
                        hi_d      = hi;
                        n_d       = n_sweeps;
                        idx_d     = '0;
                        cnt_rst_d = 1'b0;
                        dir_d     = DIR_UP;
                        state_d   = UP;
                    end else begin
                        // Zero-length request completes without touching the counter.
                        state_d = DONE;
                    end
                end
            end

            UP: begin
                if (stop) begin
                    cnt_rst_d = 1'b1;
                    dir_d     = DIR_UP;
                    state_d   = IDLE;
                end else if (count == (hi_q - N'(1))) begin
                    dir_d   = DIR_DN;
                    state_d = DOWN;
                end
            end

            DOWN: begin
                if (stop) begin
                    cnt_rst_d = 1'b1;
                    dir_d     = DIR_UP;
                    state_d   = IDLE;
                end else if (count == N'(1)) begin
                    // n_q is never zero here, so n_q - 1 cannot underflow.
                    if (idx_q == (n_q - SW'(1))) begin
                        cnt_rst_d = 1'b1;
                        dir_d     = DIR_UP;
                        state_d   = DONE;
                    end else begin
                        idx_d   = idx_q + SW'(1);
                        dir_d   = DIR_UP;
                        state_d = UP;
                    end
                end
            end

            DONE: begin
                cnt_rst_d = 1'b1;
                dir_d     = DIR_UP;
                state_d   = IDLE;
            end

            default: begin
                cnt_rst_d = 1'b1;
                dir_d     = DIR_UP;
                state_d   = IDLE;
            end
        endcase
    end

    // State, latched request and registered counter controls.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            hi_q      <= '0;
            n_q       <= '0;
            idx_q     <= '0;
            cnt_rst_q <= 1'b1;
            dir_q     <= DIR_UP;
        end else begin
            state_q   <= state_d;
            hi_q      <= hi_d;
            n_q       <= n_d;
            idx_q     <= idx_d;
            cnt_rst_q <= cnt_rst_d;
            dir_q     <= dir_d;
        end
    end

    assign dir       = dir_q;
    assign busy      = running;
    assign done      = (state_q == DONE);
    assign sweep_idx = idx_q;

endmodule

// File: tb/tb_updown_sweep_ctrl.sv
// Scoreboard bench for updown_sweep_ctrl: stimulus queues per-cycle expectations,
// a negedge monitor pops and compares them.
module tb_updown_sweep_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic       stop;
    logic [3:0] hi;
    logic [3:0] n_sweeps;
    logic [3:0] count;
    logic       dir;
    logic       busy;
    logic [3:0] sweep_idx;
    logic       done;

    int cyc = 0;
    int vectors = 0;
    int miscompares = 0;

    typedef struct {
        int         cyc;
        string      tag;
        logic [3:0] cnt;
        logic       busy;
        logic       done;
        logic [3:0] idx;
        logic       idx_chk;
        logic       dir;
        logic       dir_chk;
    } exp_t;

    exp_t q[$];

    updown_sweep_ctrl #(
        .N  (4),
        .SW (4)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .stop      (stop),
        .hi        (hi),
        .n_sweeps  (n_sweeps),
        .count     (count),
        .dir       (dir),
        .busy      (busy),
        .sweep_idx (sweep_idx),
        .done      (done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: compare every expectation due at this cycle.
    always @(negedge clk) begin
        while (q.size() > 0 && q[0].cyc <= cyc) begin
            exp_t e;
            e = q.pop_front();
            vectors++;
            if (e.cyc != cyc) begin
                miscompares++;
                $display("FAIL %s missed: due cyc=%0d, now cyc=%0d", e.tag, e.cyc, cyc);
            end else if (count !== e.cnt || busy !== e.busy || done !== e.done ||
                         (e.idx_chk && sweep_idx !== e.idx) ||
                         (e.dir_chk && dir !== e.dir)) begin
                miscompares++;
                $display("FAIL %s cyc=%0d got cnt=%0d busy=%b done=%b idx=%0d dir=%b want cnt=%0d busy=%b done=%b idx=%0d(chk %b) dir=%b(chk %b)",
                         e.tag, cyc, count, busy, done, sweep_idx, dir,
                         e.cnt, e.busy, e.done, e.idx, e.idx_chk, e.dir, e.dir_chk);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input int off, input string tag, input int cnt, input bit b,
                        input bit d, input int idx, input bit ic, input bit dr, input bit dc);
        exp_t e;
        e.cyc     = cyc + off;
        e.tag     = tag;
        e.cnt     = 4'(cnt);
        e.busy    = b;
        e.done    = d;
        e.idx     = 4'(idx);
        e.idx_chk = ic;
        e.dir     = dr;
        e.dir_chk = dc;
        q.push_back(e);
    endtask

    // Full sweep with triangle model; optional ignored start pulses driven after edge
    // ign_a / ign_b (k counted from E0).
    task automatic run_sweep(input int h, input int n, input int ign_a, input int ign_b);
        int last;
        int p;
        int c;
        int idx;
        bit dr;
        hi       = 4'(h);
        n_sweeps = 4'(n);
        start    = 1'b1;
        step();
        start    = 1'b0;
        hi       = 4'd1;
        n_sweeps = 4'd1;
        last     = 2 * h * n;
        push(0, "sweep_e0", 0, 1, 0, 0, 1, 1, 1);
        for (int k = 1; k <= last + 2; k++) begin
            if (k <= last) begin
                p   = ((k - 1) % (2 * h)) + 1;
                c   = (p <= h) ? p : 2 * h - p;
                idx = (k == last) ? n - 1 : k / (2 * h);
                dr  = (p < h) ? 1'b1 : ((p < 2 * h) ? 1'b0 : 1'b1);
                push(k, (k == last) ? "sweep_done" : "sweep_run", c, k < last, k == last,
                     idx, 1, dr, k != last);
            end else begin
                push(k, "sweep_idle", 0, 0, 0, n - 1, 1, 1, 1);
            end
        end
        for (int k = 1; k <= last + 2; k++) begin
            step();
            start = (k == ign_a) || (k == ign_b);
        end
        start = 1'b0;
    endtask

    initial begin
        rst      = 1'b1;
        start    = 1'b0;
        stop     = 1'b0;
        hi       = '0;
        n_sweeps = '0;

        // Reset held three cycles.
        for (int i = 1; i <= 3; i++) push(i, "reset", 0, 0, 0, 0, 1, 1, 1);
        for (int i = 0; i < 3; i++) step();
        rst = 1'b0;

        run_sweep(3, 2, 0, 0);
        run_sweep(15, 1, 0, 0);
        run_sweep(1, 3, 0, 0);

        // Zero-length requests.
        hi = 4'd0; n_sweeps = 4'd2; start = 1'b1;
        step();
        start = 1'b0;
        push(0, "zero_hi_done", 0, 0, 1, 0, 0, 1, 0);
        push(1, "zero_hi_idle", 0, 0, 0, 0, 0, 1, 1);
        step();
        hi = 4'd3; n_sweeps = 4'd0; start = 1'b1;
        step();
        start = 1'b0;
        push(0, "zero_n_done", 0, 0, 1, 0, 0, 1, 0);
        push(1, "zero_n_idle", 0, 0, 0, 0, 0, 1, 1);
        step();

        // Abort while counting up at count=2; start in the same cycle is ignored.
        hi = 4'd3; n_sweeps = 4'd2; start = 1'b1;
        step();
        start = 1'b0;
        push(0, "stop_e0", 0, 1, 0, 0, 1, 1, 1);
        push(1, "stop_e1", 1, 1, 0, 0, 1, 1, 1);
        push(2, "stop_e2", 2, 1, 0, 0, 1, 1, 1);
        push(3, "stop_s", 0, 0, 0, 0, 1, 1, 1);
        push(4, "stop_s1", 0, 0, 0, 0, 1, 1, 1);
        push(5, "stop_s2", 0, 0, 0, 0, 1, 1, 1);
        step();
        step();
        stop = 1'b1; start = 1'b1; hi = 4'd1; n_sweeps = 4'd1;
        step();
        stop = 1'b0; start = 1'b0;
        step();
        step();

        // Start pulses during UP and during DONE are ignored.
        run_sweep(2, 1, 1, 4);

        // Mid-sweep reset during the second sweep.
        hi = 4'd2; n_sweeps = 4'd2; start = 1'b1;
        step();
        start = 1'b0;
        push(0, "mrst_e0", 0, 1, 0, 0, 1, 1, 1);
        push(1, "mrst_e1", 1, 1, 0, 0, 1, 1, 1);
        push(2, "mrst_e2", 2, 1, 0, 0, 1, 0, 1);
        push(3, "mrst_e3", 1, 1, 0, 0, 1, 0, 1);
        push(4, "mrst_e4", 0, 1, 0, 1, 1, 1, 1);
        push(5, "mrst_e5", 1, 1, 0, 1, 1, 1, 1);
        push(6, "mrst_rst", 0, 0, 0, 0, 1, 1, 1);
        push(7, "mrst_after", 0, 0, 0, 0, 1, 1, 1);
        for (int i = 0; i < 5; i++) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        step();

        // Drain the scoreboard with a bounded wait.
        for (int i = 0; i < 50 && q.size() > 0; i++) @(negedge clk);
        #1;
        if (q.size() > 0) begin
            miscompares++;
            $display("FAIL drain: %0d expectations left, want 0", q.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
